// File: rtl/boa_pmu_pkg.sv
// Shared types and helpers for the power-management sequencer.
package boa_pmu_pkg;

  // Sequencer state, also exported on the state port.
  typedef enum logic [1:0] {
    PMU_RESET = 2'd0,
    PMU_RUN   = 2'd1,
    PMU_DRAIN = 2'd2,
    PMU_OFF   = 2'd3
  } pmu_state_t;

  // Width of a counter that has to hold values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/boa_debounce.sv
// Push-button synchronizer and debouncer. The debounced level only follows
// the synchronized input once it has differed for DEBOUNCE_CYCLES samples in
// a row; rise pulses for one cycle when the debounced level goes high.
module boa_debounce
  import boa_pmu_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_level;
  logic [CW-1:0]          stab_cnt_reg;
  logic [CW-1:0]          stab_cnt_next;
  logic                   level_reg;
  logic                   level_next;
  logic                   rise_reg;
  logic                   rise_next;

  assign sync_level = sync_reg[SYNC_STAGES-1];

  // Metastability chain for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Stability counter: restarts whenever the input agrees with the current
  // debounced level, and commits the new level on the last differing sample.
  // The counter stops at CNT_LAST, so it can never wrap.
  always_comb begin
    stab_cnt_next = '0;
    level_next    = level_reg;
    rise_next     = 1'b0;
    if (sync_level != level_reg) begin
      if (stab_cnt_reg >= CNT_LAST) begin
        level_next = sync_level;
        rise_next  = sync_level;
      end else begin
        stab_cnt_next = stab_cnt_reg + 1'b1;
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt_reg <= '0;
      level_reg    <= 1'b0;
      rise_reg     <= 1'b0;
    end else begin
      stab_cnt_reg <= stab_cnt_next;
      level_reg    <= level_next;
      rise_reg     <= rise_next;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/boa_pmu_ctl.sv
// Power-management sequencer: holds core reset for a fixed time, drains
// outstanding bus traffic before gating the core clock, and brings the core
// back through a full reset sequence on wake or button press.
module boa_pmu_ctl
  import boa_pmu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DRAIN_TIMEOUT   = 1024,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       pmu_rst_req,
  input  logic       pmu_shdn_req,
  input  logic       bus_idle,
  input  logic       wake_req,
  output logic       core_rst,
  output logic       clk_en,
  output logic [1:0] state,
  output logic       drain_timeout
);

  localparam int            HW         = cnt_width(RST_HOLD_CYCLES);
  localparam int            DW         = cnt_width(DRAIN_TIMEOUT);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  pmu_state_t    state_reg;
  pmu_state_t    state_next;
  logic [HW-1:0] hold_cnt_reg;
  logic [HW-1:0] hold_cnt_next;
  logic [DW-1:0] drain_cnt_reg;
  logic [DW-1:0] drain_cnt_next;
  logic          drain_to_reg;
  logic          drain_to_next;
  logic          core_rst_reg;
  logic          clk_en_reg;

  logic          btn_level;
  logic          btn_rise;
  logic          btn_event;
  logic          reset_cause;

  boa_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  // The rise pulse coincides with the debounced level going high; qualifying
  // with the level keeps a stray pulse from ever restarting the core.
  assign btn_event   = btn_rise & btn_level;
  assign reset_cause = pmu_rst_req | btn_event;

  // Next-state, counter and sticky-flag logic. Reset requests take priority
  // over shutdown, idle and timeout in every state that honours them.
  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = hold_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    drain_to_next  = drain_to_reg;
    unique case (state_reg)
      PMU_RESET: begin
        if (btn_event) begin
          hold_cnt_next = HOLD_LOAD;
        end else if (hold_cnt_reg == '0) begin
          state_next = PMU_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      PMU_RUN: begin
        if (reset_cause) begin
          state_next    = PMU_RESET;
          hold_cnt_next = HOLD_LOAD;
        end else if (pmu_shdn_req) begin
          state_next     = PMU_DRAIN;
          drain_cnt_next = '0;
        end
      end
      PMU_DRAIN: begin
        if (reset_cause) begin
          state_next    = PMU_RESET;
          hold_cnt_next = HOLD_LOAD;
        end else if (bus_idle) begin
          state_next = PMU_OFF;
        end else if (drain_cnt_reg >= DRAIN_LAST) begin
          state_next    = PMU_OFF;
          drain_to_next = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      PMU_OFF: begin
        if (wake_req | btn_event) begin
          state_next    = PMU_RESET;
          hold_cnt_next = HOLD_LOAD;
        end
      end
      default: begin
        state_next    = PMU_RESET;
        hold_cnt_next = HOLD_LOAD;
      end
    endcase
  end

  // Sequencer registers; outputs are decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PMU_RESET;
      hold_cnt_reg  <= HOLD_LOAD;
      drain_cnt_reg <= '0;
      drain_to_reg  <= 1'b0;
      core_rst_reg  <= 1'b1;
      clk_en_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      drain_to_reg  <= drain_to_next;
      core_rst_reg  <= (state_next == PMU_RESET);
      clk_en_reg    <= (state_next != PMU_OFF);
    end
  end

  assign state         = state_reg;
  assign core_rst      = core_rst_reg;
  assign clk_en        = clk_en_reg;
  assign drain_timeout = drain_to_reg;

endmodule

// File: tb/tb_boa_pmu_ctl.sv
// Self-checking bench for boa_pmu_ctl: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_boa_pmu_ctl;
  import boa_pmu_pkg::*;

  localparam int DEB  = 8;
  localparam int HOLD = 4;
  localparam int TMO  = 16;
  localparam int SYNC = 2;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b1;
  logic       btn_raw      = 1'b0;
  logic       pmu_rst_req  = 1'b0;
  logic       pmu_shdn_req = 1'b0;
  logic       bus_idle     = 1'b0;
  logic       wake_req     = 1'b0;
  logic       core_rst;
  logic       clk_en;
  logic [1:0] state;
  logic       drain_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  boa_pmu_ctl #(
    .DEBOUNCE_CYCLES (DEB),
    .RST_HOLD_CYCLES (HOLD),
    .DRAIN_TIMEOUT   (TMO),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .pmu_rst_req   (pmu_rst_req),
    .pmu_shdn_req  (pmu_shdn_req),
    .bus_idle      (bus_idle),
    .wake_req      (wake_req),
    .core_rst      (core_rst),
    .clk_en        (clk_en),
    .state         (state),
    .drain_timeout (drain_timeout)
  );

  // ---------------- behavioural reference model ----------------
  pmu_state_t m_state;
  int         m_cnt;      // cycles already spent in the current RESET/DRAIN visit
  bit         m_flag;
  bit         m_level;
  bit         m_ev;       // button event visible to the sequencer next edge
  bit         raw_q[$];   // recent raw button samples
  bit         seen_q[$];  // recent synchronized samples (window of DEB)

  task automatic model_reset();
    m_state = PMU_RESET;
    m_cnt   = 1;
    m_flag  = 1'b0;
    m_level = 1'b0;
    m_ev    = 1'b0;
    raw_q.delete();
    seen_q.delete();
  endtask

  task automatic model_go_reset();
    m_state = PMU_RESET;
    m_cnt   = 1;
  endtask

  // One rising clock edge of the model, using the inputs present at the edge.
  task automatic model_step();
    bit ev_now;
    bit seen;
    bit all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev_now = m_ev;
    case (m_state)
      PMU_RESET: begin
        if (ev_now)            m_cnt = 1;
        else if (m_cnt >= HOLD) m_state = PMU_RUN;
        else                   m_cnt++;
      end
      PMU_RUN: begin
        if (pmu_rst_req || ev_now) model_go_reset();
        else if (pmu_shdn_req) begin
          m_state = PMU_DRAIN;
          m_cnt   = 1;
        end
      end
      PMU_DRAIN: begin
        if (pmu_rst_req || ev_now) model_go_reset();
        else if (bus_idle) m_state = PMU_OFF;
        else if (m_cnt >= TMO) begin
          m_state = PMU_OFF;
          m_flag  = 1'b1;
        end else m_cnt++;
      end
      default: begin
        if (wake_req || ev_now) model_go_reset();
      end
    endcase
    // Button: level flips once the last DEB synchronized samples all differ.
    raw_q.push_back(btn_raw);
    seen = (raw_q.size() > SYNC) ? raw_q[raw_q.size()-1-SYNC] : 1'b0;
    if (raw_q.size() > SYNC + 1) void'(raw_q.pop_front());
    seen_q.push_back(seen);
    if (seen_q.size() > DEB) void'(seen_q.pop_front());
    m_ev = 1'b0;
    if (seen_q.size() == DEB) begin
      all_diff = 1'b1;
      foreach (seen_q[i]) if (seen_q[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        m_ev    = m_level;
        seen_q.delete();
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("state", int'(state), int'(m_state));
    check_eq("core_rst", int'(core_rst), int'(m_state == PMU_RESET));
    check_eq("clk_en", int'(clk_en), int'(m_state != PMU_OFF));
    check_eq("drain_timeout", int'(drain_timeout), int'(m_flag));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_for(input pmu_state_t s, input int budget, input string tag);
    int n = 0;
    while (state != s && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, int'(state), int'(s));
  endtask

  task automatic count_in(input pmu_state_t s, input int budget, output int n);
    n = 0;
    while (state == s && n < budget) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int btn_left;
    int non_run;

    // Power-up: asynchronous reset value, then the hold sequence.
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    rst_n = 1'b1;
    count_in(PMU_RESET, 20, n);
    check_eq("pwrup_hold_cycles", n, HOLD);
    check_eq("pwrup_run", int'(state), int'(PMU_RUN));
    $display("power-up: reset held %0d cycles, state=%0d", n, state);

    // Clean shutdown: 5 busy DRAIN cycles, then idle.
    pmu_shdn_req = 1'b1;
    bus_idle     = 1'b0;
    tick();
    pmu_shdn_req = 1'b0;
    check_eq("shdn_enter", int'(state), int'(PMU_DRAIN));
    n = 1;
    repeat (5) begin
      tick();
      if (state == PMU_DRAIN) n++;
    end
    bus_idle = 1'b1;
    tick();
    bus_idle = 1'b0;
    check_eq("clean_drain_cycles", n, 6);
    check_eq("clean_off", int'(state), int'(PMU_OFF));
    check_eq("clean_clk_en", int'(clk_en), 0);
    check_eq("clean_no_timeout", int'(drain_timeout), 0);
    $display("clean shutdown: drain cycles=%0d state=%0d", n, state);

    // Wake from OFF.
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    count_in(PMU_RESET, 20, n);
    check_eq("wake1_hold_cycles", n, HOLD);
    check_eq("wake1_run", int'(state), int'(PMU_RUN));
    $display("wake: reset held %0d cycles", n);

    // Forced shutdown by timeout, then wake with the flag surviving.
    pmu_shdn_req = 1'b1;
    bus_idle     = 1'b0;
    tick();
    pmu_shdn_req = 1'b0;
    count_in(PMU_DRAIN, 40, n);
    check_eq("forced_drain_cycles", n, TMO);
    check_eq("forced_off", int'(state), int'(PMU_OFF));
    check_eq("forced_flag", int'(drain_timeout), 1);
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    count_in(PMU_RESET, 20, n);
    check_eq("wake2_hold_cycles", n, HOLD);
    check_eq("wake2_run", int'(state), int'(PMU_RUN));
    check_eq("wake2_flag_kept", int'(drain_timeout), 1);
    $display("forced shutdown: drain cycles=%0d flag=%0d", TMO, drain_timeout);

    // Debounce: bouncing button must not disturb RUN.
    non_run = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn_raw = ~btn_raw;
      tick();
      if (state != PMU_RUN) non_run++;
    end
    check_eq("bounce_no_event", non_run, 0);
    btn_raw = 1'b1;
    repeat (10) tick();
    check_eq("btn_latency_pre", int'(state), int'(PMU_RUN));
    tick();
    check_eq("btn_latency", int'(state), int'(PMU_RESET));
    wait_for(PMU_RUN, 20, "btn_back_run");
    btn_raw = 1'b0;
    repeat (14) tick();
    check_eq("btn_release_no_event", int'(state), int'(PMU_RUN));
    $display("debounce: bounce ignored, held press restarted core");

    // Priority: reset beats shutdown in RUN.
    pmu_rst_req  = 1'b1;
    pmu_shdn_req = 1'b1;
    tick();
    pmu_rst_req  = 1'b0;
    pmu_shdn_req = 1'b0;
    check_eq("prio_reset", int'(state), int'(PMU_RESET));
    wait_for(PMU_RUN, 20, "prio_back_run");
    $display("priority: state after joint request=RESET");

    // Asynchronous reset while OFF.
    pmu_shdn_req = 1'b1;
    bus_idle     = 1'b1;
    tick();
    pmu_shdn_req = 1'b0;
    wait_for(PMU_OFF, 5, "async_reach_off");
    bus_idle = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_core_rst", int'(core_rst), 1);
    check_eq("async_clk_en", int'(clk_en), 1);
    check_eq("async_state", int'(state), int'(PMU_RESET));
    check_eq("async_flag_clear", int'(drain_timeout), 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    wait_for(PMU_RUN, 20, "async_back_run");
    $display("async reset mid-OFF: outputs forced without a clock edge");

    // Randomized traffic; the second half starves bus_idle to hit timeouts.
    btn_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (btn_left == 0) begin
        btn_raw  = 1'($urandom_range(0, 1));
        btn_left = $urandom_range(1, 14);
      end
      btn_left--;
      pmu_rst_req  = ($urandom_range(0, 49) == 0);
      pmu_shdn_req = ($urandom_range(0, 9) == 0);
      bus_idle     = (cyc < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      wake_req     = ($urandom_range(0, 7) == 0);
      rst_n        = ($urandom_range(0, 399) != 0);
      tick();
    end
    $display("random: 1500 cycles compared against model");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
